// File: rtl/spi_pkg.sv
// Shared encodings for the SPI register controller: FSM states, register map and
// command byte layout.
package spi_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCmd   = 3'd1,
    StWrite = 3'd2,
    StRead  = 3'd3,
    StError = 3'd4
  } state_e;

  localparam logic [1:0] ADDR_ID      = 2'd0;
  localparam logic [1:0] ADDR_CTRL    = 2'd1;
  localparam logic [1:0] ADDR_COUNT   = 2'd2;
  localparam logic [1:0] ADDR_SCRATCH = 2'd3;

  localparam int unsigned CMD_RW_BIT  = 7;
  localparam int unsigned CMD_RSV_MSB = 6;
  localparam int unsigned CMD_RSV_LSB = 2;

  localparam logic [7:0] ID_VALUE_DEFAULT = 8'hA5;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pins; the reset value is chosen per pin so
// that no spurious edge appears when reset is released.
module sync_2ff #(
  parameter int unsigned     Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Frames the SPI byte stream into command/data transactions against a four-entry
// register map (ID, CTRL, COUNT snapshot, SCRATCH) and feeds read data back to the slave.
module spi_reg_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned              DATAWIDTH_BUS = 8,
  parameter int unsigned              STATE_SIZE    = 3,
  parameter logic [DATAWIDTH_BUS-1:0] ID_VALUE      = ID_VALUE_DEFAULT
) (
  input  logic                     SPI_REG_CTRL_CLOCK_50,
  input  logic                     SPI_REG_CTRL_RESET_InHigh,
  input  logic                     SPI_REG_CTRL_SS_InLow,
  input  logic                     SPI_REG_CTRL_newData_InHigh,
  input  logic [DATAWIDTH_BUS-1:0] SPI_REG_CTRL_rxData_In,
  input  logic [DATAWIDTH_BUS-1:0] SPI_REG_CTRL_count_In,
  output logic [DATAWIDTH_BUS-1:0] SPI_REG_CTRL_txData_Out,
  output logic [DATAWIDTH_BUS-1:0] SPI_REG_CTRL_ctrl_Out,
  output logic                     SPI_REG_CTRL_clrCount_OutHigh,
  output logic                     SPI_REG_CTRL_wrStrobe_OutHigh,
  output logic                     SPI_REG_CTRL_err_OutHigh,
  output logic [STATE_SIZE-1:0]    SPI_REG_CTRL_state_Out
);

  logic clk;
  logic rst;
  assign clk = SPI_REG_CTRL_CLOCK_50;
  assign rst = SPI_REG_CTRL_RESET_InHigh;

  logic ss_sync;
  logic ss_prev_q;
  logic ss_fall;
  logic ss_rise;

  sync_2ff #(
    .Width      (1),
    .ResetValue (1'b1)
  ) u_ss_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (SPI_REG_CTRL_SS_InLow),
    .q_o   (ss_sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ss_prev_q <= 1'b1;
    else     ss_prev_q <= ss_sync;
  end

  assign ss_fall = ss_prev_q & ~ss_sync;
  assign ss_rise = ~ss_prev_q & ss_sync;

  state_e                   state_q, state_d;
  logic [1:0]               addr_q, addr_d;
  logic [DATAWIDTH_BUS-1:0] ctrl_q, ctrl_d;
  logic [DATAWIDTH_BUS-1:0] scratch_q, scratch_d;
  logic [DATAWIDTH_BUS-1:0] snap_q, snap_d;
  logic [DATAWIDTH_BUS-1:0] tx_q, tx_d;
  logic                     err_q, err_d;
  logic                     wr_q, wr_d;
  logic                     clr_q, clr_d;

  logic [1:0]               addr_inc;
  logic [DATAWIDTH_BUS-1:0] rx;
  logic                     new_data;

  assign addr_inc = addr_q + 2'd1;
  assign rx       = SPI_REG_CTRL_rxData_In;
  assign new_data = SPI_REG_CTRL_newData_InHigh;

  function automatic logic [DATAWIDTH_BUS-1:0] read_reg(
    input logic [1:0]               addr,
    input logic [DATAWIDTH_BUS-1:0] ctrl,
    input logic [DATAWIDTH_BUS-1:0] count,
    input logic [DATAWIDTH_BUS-1:0] scratch
  );
    logic [DATAWIDTH_BUS-1:0] val;
    case (addr)
      ADDR_CTRL:    val = ctrl;
      ADDR_COUNT:   val = count;
      ADDR_SCRATCH: val = scratch;
      default:      val = ID_VALUE;
    endcase
    return val;
  endfunction

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    snap_d    = snap_q;
    tx_d      = tx_q;
    err_d     = err_q;
    wr_d      = 1'b0;
    clr_d     = 1'b0;

    // Frame end wins over a byte arriving in the same cycle: that byte is dropped.
    if (ss_rise) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (ss_fall) begin
            state_d = StCmd;
            err_d   = 1'b0;
            tx_d    = '0;
          end
        end
        StCmd: begin
          if (new_data) begin
            if (|rx[CMD_RSV_MSB:CMD_RSV_LSB]) begin
              state_d = StError;
              err_d   = 1'b1;
            end else if (rx[CMD_RW_BIT]) begin
              state_d = StRead;
              addr_d  = rx[1:0];
              snap_d  = SPI_REG_CTRL_count_In;
              tx_d    = read_reg(rx[1:0], ctrl_q, SPI_REG_CTRL_count_In, scratch_q);
            end else begin
              state_d = StWrite;
              addr_d  = rx[1:0];
            end
          end
        end
        StWrite: begin
          if (new_data) begin
            case (addr_q)
              ADDR_CTRL:    ctrl_d    = rx;
              ADDR_COUNT:   clr_d     = 1'b1;
              ADDR_SCRATCH: scratch_d = rx;
              default:      ;
            endcase
            wr_d   = 1'b1;
            addr_d = addr_inc;
          end
        end
        StRead: begin
          if (new_data) begin
            addr_d = addr_inc;
            // Landing on COUNT mid-burst takes a fresh snapshot.
            if (addr_inc == ADDR_COUNT) begin
              snap_d = SPI_REG_CTRL_count_In;
              tx_d   = SPI_REG_CTRL_count_In;
            end else begin
              tx_d = read_reg(addr_inc, ctrl_q, snap_q, scratch_q);
            end
          end
        end
        StError: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      ctrl_q    <= '0;
      scratch_q <= '0;
      snap_q    <= '0;
      tx_q      <= '0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
      snap_q    <= snap_d;
      tx_q      <= tx_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
      clr_q     <= clr_d;
    end
  end

  assign SPI_REG_CTRL_txData_Out       = tx_q;
  assign SPI_REG_CTRL_ctrl_Out         = ctrl_q;
  assign SPI_REG_CTRL_clrCount_OutHigh = clr_q;
  assign SPI_REG_CTRL_wrStrobe_OutHigh = wr_q;
  assign SPI_REG_CTRL_err_OutHigh      = err_q;
  assign SPI_REG_CTRL_state_Out        = STATE_SIZE'(state_q);

endmodule
